// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: decodes E0/F0 prefixed scan codes into a held-key bitmap
// and a small first-word-fall-through event FIFO for the game logic.
module ps2_key_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    output logic [7:0] keys_held,
    output logic       evt_valid,
    output logic [3:0] evt_data,
    input  logic       evt_ready,
    output logic       evt_overflow,
    input  logic       ovf_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      keys_q, keys_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;

    logic            push;
    logic [3:0]      push_data;
    logic            act_make, act_brk;
    logic [2:0]      act_idx;
    logic            pop, empty, full, push_ok;

    // {hit, idx} for single-byte codes
    function automatic logic [3:0] map_norm(input logic [7:0] c);
        case (c)
            8'h1C:   map_norm = 4'b1_000;
            8'h23:   map_norm = 4'b1_001;
            8'h1D:   map_norm = 4'b1_010;
            8'h1B:   map_norm = 4'b1_011;
            8'h3B:   map_norm = 4'b1_100;
            8'h5A:   map_norm = 4'b1_101;
            8'h76:   map_norm = 4'b1_110;
            8'h29:   map_norm = 4'b1_111;
            default: map_norm = 4'b0_000;
        endcase
    endfunction

    // {hit, idx} for codes following E0
    function automatic logic [3:0] map_ext(input logic [7:0] c);
        case (c)
            8'h6B:   map_ext = 4'b1_000;
            8'h74:   map_ext = 4'b1_001;
            8'h75:   map_ext = 4'b1_010;
            8'h72:   map_ext = 4'b1_011;
            default: map_ext = 4'b0_000;
        endcase
    endfunction

    logic [3:0] norm_hit, ext_hit;
    assign norm_hit = map_norm(code_byte);
    assign ext_hit  = map_ext(code_byte);

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        act_make = 1'b0;
        act_brk  = 1'b0;
        act_idx  = 3'd0;
        if (code_valid) begin
            tmo_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (code_byte == 8'hE0) begin
                        state_d = StExt;
                    end else if (code_byte == 8'hF0) begin
                        state_d = StBrk;
                    end else begin
                        act_make = norm_hit[3];
                        act_idx  = norm_hit[2:0];
                    end
                end
                StExt: begin
                    if (code_byte == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (code_byte != 8'hE0) begin
                        state_d  = StIdle;
                        act_make = ext_hit[3];
                        act_idx  = ext_hit[2:0];
                    end
                end
                StBrk: begin
                    if (code_byte != 8'hF0) begin
                        state_d = StIdle;
                        act_brk = norm_hit[3];
                        act_idx = norm_hit[2:0];
                    end
                end
                StExtBrk: begin
                    state_d = StIdle;
                    act_brk = ext_hit[3];
                    act_idx = ext_hit[2:0];
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            // Abandon a dangling prefix if the rest of the sequence never arrives
            if (tmo_q == TmoLast) begin
                state_d = StIdle;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Typematic repeats and stray breaks produce no events
    always_comb begin
        keys_d    = keys_q;
        push      = 1'b0;
        push_data = 4'd0;
        if (act_make && !keys_q[act_idx]) begin
            keys_d[act_idx] = 1'b1;
            push            = 1'b1;
            push_data       = {1'b1, act_idx};
        end else if (act_brk && keys_q[act_idx]) begin
            keys_d[act_idx] = 1'b0;
            push            = 1'b1;
            push_data       = {1'b0, act_idx};
        end
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && evt_ready;
    assign push_ok = push && (!full || pop);

    always_comb begin
        ovf_d = ovf_q;
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            tmo_q    <= '0;
            keys_q   <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            keys_q  <= keys_d;
            ovf_q   <= ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    assign keys_held    = keys_q;
    assign evt_valid    = !empty;
    assign evt_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_overflow = ovf_q;

endmodule
